// File: rtl/hack_exec_ctrl.sv
// Multi-cycle Hack CPU control/register stage around an external combinational ALU.
// Fetch/M-read/M-write use req/ack handshakes; A, D and PC commit on the retire edge.
module hack_exec_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic [5:0]  alu_signal,
   input  logic [15:0] alu_out,
   output logic [15:0] pc,
   output logic [15:0] a_reg,
   output logic [15:0] d_reg,
   output logic        instr_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MREAD,
      S_EXEC,
      S_MWRITE
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] instr_reg, m_reg, res_reg;
   logic        jump_reg;
   logic        is_c, zr, ng, jump_now;
   logic        retire, commit, commit_jump;
   logic [15:0] commit_res, pc_inc;

   assign is_c     = instr_reg[15];
   assign zr       = (alu_out == 16'h0000);
   assign ng       = alu_out[15];
   assign jump_now = (instr_reg[2] & ng) | (instr_reg[1] & zr) | (instr_reg[0] & ~ng & ~zr);
   assign pc_inc   = pc + 16'd1;

   // A write to M defers the commit, so the result and jump decision are replayed from registers.
   assign commit_res  = (state == S_MWRITE) ? res_reg  : alu_out;
   assign commit_jump = (state == S_MWRITE) ? jump_reg : jump_now;

   assign imem_addr  = pc;
   assign dmem_addr  = a_reg;
   assign dmem_wdata = res_reg;
   assign alu_x      = d_reg;
   assign alu_y      = instr_reg[12] ? m_reg : a_reg;
   assign alu_signal = instr_reg[11:6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      dmem_rd   = 1'b0;
      dmem_wr   = 1'b0;
      retire    = 1'b0;
      commit    = 1'b0;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (!is_c) begin
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end else if (instr_reg[12]) begin
               state_nxt = S_MREAD;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_MREAD: begin
            dmem_rd = 1'b1;
            if (dmem_ack) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (instr_reg[3]) begin
               state_nxt = S_MWRITE;
            end else begin
               commit    = 1'b1;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_MWRITE: begin
            dmem_wr = 1'b1;
            if (dmem_ack) begin
               commit    = 1'b1;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         a_reg      <= 16'h0000;
         d_reg      <= 16'h0000;
         instr_reg  <= 16'h0000;
         m_reg      <= 16'h0000;
         res_reg    <= 16'h0000;
         jump_reg   <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         instr_done <= retire;
         if (state == S_FETCH && imem_ack) instr_reg <= imem_rdata;
         if (state == S_DECODE && !is_c) begin
            a_reg <= instr_reg;
            pc    <= pc_inc;
         end
         if (state == S_MREAD && dmem_ack) m_reg <= dmem_rdata;
         if (state == S_EXEC) begin
            res_reg  <= alu_out;
            jump_reg <= jump_now;
         end
         // Jump target uses the pre-instruction A even when the same instruction writes A.
         if (commit) begin
            if (instr_reg[4]) d_reg <= commit_res;
            if (instr_reg[5]) a_reg <= commit_res;
            pc <= commit_jump ? a_reg : pc_inc;
         end
      end
   end

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Bench for hack_exec_ctrl: behavioural Hack ALU, req/ack memories with programmable waits,
// and an instruction-level Hack machine model compared at every retire.
module tb_hack_exec_ctrl;

   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_rd;
   logic        dmem_wr;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [5:0]  alu_signal;
   logic [15:0] alu_out;
   logic [15:0] pc;
   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic        instr_done;

   int total = 0;
   int bad   = 0;

   logic [15:0] rom [int];
   logic [15:0] ram [int];
   logic [15:0] mm  [int];
   int          wi = 0;
   int          wd = 0;
   logic        idle_ack_i = 1'b0;
   logic        idle_ack_d = 1'b0;
   logic [15:0] mpc, ma, md;

   int          ci, cd;
   logic        pend_wr;
   logic [15:0] pend_addr, pend_dat;

   hack_exec_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .alu_x(alu_x), .alu_y(alu_y), .alu_signal(alu_signal), .alu_out(alu_out),
      .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .instr_done(instr_done)
   );

   function automatic logic [15:0] hack_alu(input logic [15:0] x0, input logic [15:0] y0,
                                            input logic [5:0] c);
      logic [15:0] x, y, o;
      x = c[5] ? 16'h0000 : x0;
      x = c[4] ? ~x : x;
      y = c[3] ? 16'h0000 : y0;
      y = c[2] ? ~y : y;
      o = c[1] ? (x + y) : (x & y);
      return c[0] ? ~o : o;
   endfunction

   function automatic logic [15:0] rd_rom(input logic [15:0] a);
      return rom.exists(int'(a)) ? rom[int'(a)] : 16'h0000;
   endfunction

   function automatic logic [15:0] rd_mm(input logic [15:0] a);
      return mm.exists(int'(a)) ? mm[int'(a)] : 16'h0000;
   endfunction

   assign alu_out = hack_alu(alu_x, alu_y, alu_signal);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: decides acks shortly after each rising edge for the next edge.
   initial begin
      ci = 0; cd = 0; pend_wr = 1'b0; pend_addr = 16'h0; pend_dat = 16'h0;
      imem_ack = 1'b0; imem_rdata = 16'h0; dmem_ack = 1'b0; dmem_rdata = 16'h0;
      forever begin
         @(posedge clk);
         #2;
         if (pend_wr && rst_n) ram[int'(pend_addr)] = pend_dat;
         pend_wr = 1'b0;
         if (imem_req) begin
            if (ci >= wi) begin
               imem_ack = 1'b1; imem_rdata = rd_rom(imem_addr); ci = 0;
            end else begin
               imem_ack = 1'b0; imem_rdata = 16'($urandom); ci++;
            end
         end else begin
            ci = 0; imem_ack = idle_ack_i; imem_rdata = 16'($urandom);
         end
         if (dmem_rd || dmem_wr) begin
            if (cd >= wd) begin
               dmem_ack   = 1'b1;
               dmem_rdata = ram.exists(int'(dmem_addr)) ? ram[int'(dmem_addr)] : 16'h0000;
               if (dmem_wr) begin
                  pend_wr = 1'b1; pend_addr = dmem_addr; pend_dat = dmem_wdata;
               end
               cd = 0;
            end else begin
               dmem_ack = 1'b0; dmem_rdata = 16'($urandom); cd++;
            end
         end else begin
            cd = 0; dmem_ack = idle_ack_d; dmem_rdata = 16'($urandom);
         end
      end
   end

   // Leaves the bench at the falling edge of the first FETCH cycle after release.
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (imem_req !== 1'b0 || dmem_rd !== 1'b0 || dmem_wr !== 1'b0 || instr_done !== 1'b0 ||
          pc !== RST_PC || a_reg !== 16'h0 || d_reg !== 16'h0)
         begin bad++; $display("FAIL in_reset: req=%b rd=%b wr=%b done=%b pc=%h a=%h d=%h want all 0",
                               imem_req, dmem_rd, dmem_wr, instr_done, pc, a_reg, d_reg); end
      rst_n = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b0)
         begin bad++; $display("FAIL idle_no_req: imem_req=%b want 0", imem_req); end
      @(negedge clk);
      mpc = RST_PC; ma = 16'h0; md = 16'h0;
   endtask

   // Executes n instructions, comparing the DUT against the instruction-level model.
   task automatic run_instrs(input int n);
      for (int k = 0; k < n; k++) begin
         logic [15:0] ins, y, res, ea, ed, epc;
         logic        isc, rdm, wrm, jmp, seen;
         int          lat, exec_c, nrd, nwr, cyc;
         ins = rd_rom(mpc);
         isc = ins[15];
         rdm = isc & ins[12];
         wrm = isc & ins[3];
         y = 16'h0; res = 16'h0; exec_c = 0;
         if (!isc) begin
            ea = ins; ed = md; epc = mpc + 16'd1; lat = 2 + wi;
         end else begin
            y   = rdm ? rd_mm(ma) : ma;
            res = hack_alu(md, y, ins[11:6]);
            jmp = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0) ||
                  (ins[0] && $signed(res) > 0);
            ea  = ins[5] ? res : ma;
            ed  = ins[4] ? res : md;
            epc = jmp ? ma : mpc + 16'd1;
            exec_c = 2 + wi + (rdm ? 1 + wd : 0);
            lat = exec_c + 1 + (wrm ? 1 + wd : 0);
         end
         total++;
         if (imem_req !== 1'b1 || imem_addr !== mpc)
            begin bad++; $display("FAIL fetch_addr: req=%b addr=%h want 1 %h", imem_req, imem_addr, mpc); end
         nrd = 0; nwr = 0; cyc = 0; seen = 1'b0;
         for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            cyc = c;
            if (instr_done) begin seen = 1'b1; break; end
            total++;
            if (pc !== mpc || a_reg !== ma || d_reg !== md)
               begin bad++; $display("FAIL hold: pc=%h a=%h d=%h want %h %h %h", pc, a_reg, d_reg, mpc, ma, md); end
            if (dmem_rd) begin
               nrd++; total++;
               if (dmem_addr !== ma)
                  begin bad++; $display("FAIL rd_addr: got %h want %h", dmem_addr, ma); end
            end
            if (dmem_wr) begin
               nwr++; total++;
               if (dmem_addr !== ma || dmem_wdata !== res)
                  begin bad++; $display("FAIL wr: addr=%h data=%h want %h %h", dmem_addr, dmem_wdata, ma, res); end
            end
            if (isc && c == exec_c) begin
               total++;
               if (alu_signal !== ins[11:6] || alu_x !== md || alu_y !== y)
                  begin bad++; $display("FAIL alu_ops: sig=%b x=%h y=%h want %b %h %h",
                                        alu_signal, alu_x, alu_y, ins[11:6], md, y); end
            end
         end
         if (!seen) begin
            bad++; $display("FAIL timeout: no instr_done for instr %h at pc %h", ins, mpc);
            return;
         end
         total++;
         if (cyc !== lat)
            begin bad++; $display("FAIL latency: instr %h took %0d want %0d", ins, cyc, lat); end
         total++;
         if (nrd !== (rdm ? 1 + wd : 0) || nwr !== (wrm ? 1 + wd : 0))
            begin bad++; $display("FAIL req_cycles: rd=%0d wr=%0d want %0d %0d",
                                  nrd, nwr, rdm ? 1 + wd : 0, wrm ? 1 + wd : 0); end
         if (wrm) mm[int'(ma)] = res;
         mpc = epc; ma = ea; md = ed;
         total++;
         if (pc !== mpc || a_reg !== ma || d_reg !== md)
            begin bad++; $display("FAIL retire: instr %h pc=%h a=%h d=%h want %h %h %h",
                                  ins, pc, a_reg, d_reg, mpc, ma, md); end
      end
   endtask

   task automatic test_reset();
      rom.delete(); wi = 0; wd = 0; idle_ack_i = 1'b1; idle_ack_d = 1'b0;
      do_reset();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || pc !== 16'h0 || a_reg !== 16'h0 || d_reg !== 16'h0)
         begin bad++; $display("FAIL first_fetch: req=%b addr=%h pc=%h a=%h d=%h want 1 0000 0 0 0",
                               imem_req, imem_addr, pc, a_reg, d_reg); end
      idle_ack_i = 1'b0;
   endtask

   task automatic test_d_eq_a();
      rom.delete(); rom[0] = 16'h0005; rom[1] = 16'hEC10; wi = 0; wd = 0;
      do_reset();
      run_instrs(2);
      total++;
      if (a_reg !== 16'd5 || d_reg !== 16'd5 || pc !== 16'd2)
         begin bad++; $display("FAIL d_eq_a: a=%h d=%h pc=%h want 5 5 2", a_reg, d_reg, pc); end
   endtask

   task automatic test_mwrite_wait();
      rom.delete();
      rom[0] = 16'd7; rom[1] = 16'hEC10; rom[2] = 16'd100; rom[3] = 16'hE7C8;
      wi = 0; wd = 3;
      do_reset();
      run_instrs(4);
      total++;
      if (ram[100] !== 16'd8 || a_reg !== 16'd100 || d_reg !== 16'd7 || pc !== 16'd4)
         begin bad++; $display("FAIL m_eq_d1: M=%h a=%h d=%h pc=%h want 8 100 7 4", ram[100], a_reg, d_reg, pc); end
   endtask

   task automatic test_am_read();
      rom.delete();
      rom[0] = 16'd20; rom[1] = 16'hEE88; rom[2] = 16'd20; rom[3] = 16'hFDE8;
      wi = 1; wd = 2;
      do_reset();
      run_instrs(2);
      total++;
      if (ram[20] !== 16'hFFFF)
         begin bad++; $display("FAIL m_neg1: M=%h want ffff", ram[20]); end
      run_instrs(2);
      total++;
      if (ram[20] !== 16'h0000 || a_reg !== 16'h0000 || pc !== 16'd4)
         begin bad++; $display("FAIL am_inc: M=%h a=%h pc=%h want 0 0 4", ram[20], a_reg, pc); end
   endtask

   task automatic test_jumps();
      rom.delete(); rom[0] = 16'd9; rom[1] = 16'hEA87; wi = 0; wd = 0;
      do_reset(); run_instrs(2);
      total++;
      if (pc !== 16'd9) begin bad++; $display("FAIL jmp: pc=%h want 9", pc); end
      rom.delete(); rom[0] = 16'd3; rom[1] = 16'hEC10; rom[2] = 16'd9; rom[3] = 16'hE301;
      do_reset(); run_instrs(4);
      total++;
      if (pc !== 16'd9) begin bad++; $display("FAIL jgt_taken: pc=%h want 9", pc); end
      rom[0] = 16'd0;
      do_reset(); run_instrs(4);
      total++;
      if (pc !== 16'd4) begin bad++; $display("FAIL jgt_not_taken: pc=%h want 4", pc); end
      rom.delete(); rom[0] = 16'hEEA0; rom[1] = 16'hEA87; rom[65535] = 16'h0042;
      do_reset(); run_instrs(3);
      total++;
      if (pc !== 16'h0000 || a_reg !== 16'h0042)
         begin bad++; $display("FAIL pc_wrap: pc=%h a=%h want 0000 0042", pc, a_reg); end
   endtask

   task automatic test_reset_mid();
      logic got;
      rom.delete();
      rom[0] = 16'd7; rom[1] = 16'hEC10; rom[2] = 16'd101; rom[3] = 16'hE7C8;
      wi = 0; wd = 8;
      do_reset();
      run_instrs(3);
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dmem_wr) begin got = 1'b1; break; end
      end
      total++;
      if (!got) begin bad++; $display("FAIL mwrite_seen: dmem_wr=%b want 1", dmem_wr); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (dmem_wr !== 1'b0 || imem_req !== 1'b0 || pc !== RST_PC || a_reg !== 16'h0 ||
          d_reg !== 16'h0 || instr_done !== 1'b0)
         begin bad++; $display("FAIL async_reset: wr=%b req=%b pc=%h a=%h d=%h done=%b want 0 0 %h 0 0 0",
                               dmem_wr, imem_req, pc, a_reg, d_reg, instr_done, RST_PC); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC)
         begin bad++; $display("FAIL refetch: req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC); end
      mpc = RST_PC; ma = 16'h0; md = 16'h0;
      run_instrs(2);
      total++;
      if (ram.exists(101))
         begin bad++; $display("FAIL no_partial_write: M[101]=%h want unwritten", ram[101]); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         rom.delete();
         for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 2) == 0) rom[i] = {1'b0, 15'($urandom_range(0, 63))};
            else                           rom[i] = 16'($urandom) | 16'h8000;
         end
         wi = $urandom_range(0, 3);
         wd = $urandom_range(0, 3);
         idle_ack_i = 1'($urandom);
         idle_ack_d = 1'($urandom);
         do_reset();
         run_instrs(40);
      end
      idle_ack_i = 1'b0; idle_ack_d = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      mpc = 16'h0; ma = 16'h0; md = 16'h0;
      #1;
      test_reset();
      test_d_eq_a();
      test_mwrite_wait();
      test_am_read();
      test_jumps();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hack_exec_ctrl.md
Name: hack_exec_ctrl

Overview:
- Multi-cycle Hack CPU control/register stage wrapped around the combinational Hack ALU.
- Fetches instructions over a req/ack instruction port and decodes A- and C-instructions.
- Drives the ALU operands and 6-bit control word, consumes the ALU result, and updates the A, D and PC registers.
- Performs M reads/writes over a req/ack data port; the ALU itself sits outside this block.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  instruction fetch request; high iff state==FETCH
imem_addr  out  16  fetch address = pc
imem_ack  in  1  fetch completes on the rising edge where imem_req && imem_ack
imem_rdata  in  16  instruction word, sampled on the ack edge
dmem_rd  out  1  data read request; high iff state==MREAD
dmem_wr  out  1  data write request; high iff state==MWRITE
dmem_addr  out  16  = a_reg
dmem_wdata  out  16  = res_reg
dmem_ack  in  1  data transfer completes on the edge where (dmem_rd|dmem_wr) && dmem_ack
dmem_rdata  in  16  M value, sampled on the read ack edge
alu_x  out  16  = d_reg
alu_y  out  16  = instr_reg[12] ? m_reg : a_reg
alu_signal  out  6  = instr_reg[11:6] (zx,nx,zy,ny,f,no)
alu_out  in  16  ALU result
pc  out  16  program counter
a_reg  out  16  A register
d_reg  out  16  D register
instr_done  out  1  one-cycle pulse in the cycle after each retire edge

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low, named rst_n; clock is named clk. The reset polarity and synchronicity are fixed.
- Reset values: state=IDLE, pc=RESET_PC, a_reg=d_reg=instr_reg=m_reg=res_reg=0, instr_done=0. All request outputs are therefore 0.
- States: IDLE, FETCH, DECODE, MREAD, EXEC, MWRITE.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH: hold imem_req until ack. On the ack edge, instr_reg <= imem_rdata and go to DECODE. Zero-wait ack is allowed (ack in the first FETCH cycle).
- DECODE, A-instruction (instr[15]==0): a_reg <= instr; pc <= pc+1; retire; go to FETCH.
- DECODE, C-instruction: go to MREAD if instr[12]==1, else go to EXEC. Bits instr[14:13] are ignored.
- MREAD: hold dmem_rd until ack. On the ack edge, m_reg <= dmem_rdata and go to EXEC.
- EXEC: res_reg <= alu_out. Flags are computed from alu_out: zr = (alu_out==0), ng = alu_out[15].
  - If dest M (instr[3]) is set: latch the jump decision, go to MWRITE, and leave A, D and PC unchanged.
  - Otherwise: commit and retire, then go to FETCH.
- MWRITE: hold dmem_wr with dmem_addr = old a_reg and dmem_wdata = res_reg. On the ack edge: commit, retire, go to FETCH.
- Commit, all on the retire edge:
  - d_reg <= result if instr[4].
  - a_reg <= result if instr[5].
  - pc <= jump ? a_reg(old) : pc+1.
  - jump = (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr), with j1,j2,j3 = instr[2:0].
  - The jump target and the M address always use the A value from before this instruction, including for AM= and A=...;JMP.
- Arithmetic:
  - All 16-bit.
  - pc+1 wraps 16'hFFFF -> 16'h0000.
  - ALU carry out is not used.
- Latency with zero-wait memories:
  - A-instruction: 2 cycles.
  - C-instruction without M: 3 cycles.
  - Each M read or M write adds 1 cycle plus its wait cycles.
- Request signals are pure state decodes. They are never asserted in IDLE or DECODE, and never simultaneously.
- Reset asserted mid-operation: immediate return to reset values; requests drop asynchronously; no partial commit. The first fetch after release is from RESET_PC.
- Ack received while no request is asserted: ignored.

Test Plan:
- Reset release with imem_ack tied 1 -> IDLE for 1 cycle, then imem_req=1 with imem_addr=0000; pc, a_reg, d_reg all 0; instr_done=0 throughout reset.
- Program 0x0005 (@5), 0xEC10 (D=A) -> a_reg=5 after 2 cycles, d_reg=5 after 3 more; alu_signal=6'b110000 during EXEC; pc=2; two instr_done pulses.
- @7, D=A, @100, 0xE7C8 (M=D+1) with dmem_ack delayed 3 cycles -> dmem_wr held 4 cycles at addr 100 with wdata 8; pc advances only on the ack edge; a_reg and d_reg unchanged by the final instruction.
- M[20]=0xFFFF, then @20, 0xFDE8 (AM=M+1) -> dmem_rd at 20, then dmem_wr at addr 20 (old A) with data 0; a_reg=0 afterwards.
- Jumps: @9, 0xEA87 (0;JMP) -> pc=9. Separately with D=3: @9, 0xE301 (D;JGT) -> pc=9. With D=0, 0xE301 -> pc=old+1. With pc=FFFF executing an A-instruction -> pc=0000.
- rst_n low during MWRITE wait -> dmem_wr drops immediately; no register change; the next fetch after release is at RESET_PC.
